dcache_mem_arbiter: RTL and testbench
=====================================

# dcache_mem_arbiter

Multiplexes the per-consumer miss/write-through request ports of `dcache` onto a smaller number of external memory channels. It sits directly downstream of `dcache`: its consumer side connects to the dcache `controller_*` ports, and its memory side drives global data memory. Each channel is an independent request/response state machine. A free channel claims the lowest-indexed pending consumer that is not already being served.

## Interface
Parameters:
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 8, dcache-side request ports
- NUM_CHANNELS, 8, memory channels (1..NUM_CONSUMERS)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- consumer_read_valid  in  NUM_CONSUMERS  read request per consumer
- consumer_read_address  in  NUM_CONSUMERS x ADDR_BITS  read address
- consumer_read_ready  out  NUM_CONSUMERS  read data valid / ack
- consumer_read_data  out  NUM_CONSUMERS x DATA_BITS  returned data
- consumer_write_valid  in  NUM_CONSUMERS  write request
- consumer_write_address  in  NUM_CONSUMERS x ADDR_BITS  write address
- consumer_write_data  in  NUM_CONSUMERS x DATA_BITS  write data
- consumer_write_ready  out  NUM_CONSUMERS  write ack
- mem_read_valid  out  NUM_CHANNELS  memory read request
- mem_read_address  out  NUM_CHANNELS x ADDR_BITS
- mem_read_ready  in  NUM_CHANNELS  memory read complete
- mem_read_data  in  NUM_CHANNELS x DATA_BITS
- mem_write_valid  out  NUM_CHANNELS  memory write request
- mem_write_address  out  NUM_CHANNELS x ADDR_BITS
- mem_write_data  out  NUM_CHANNELS x DATA_BITS
- mem_write_ready  in  NUM_CHANNELS  memory write complete

## Operation
- Per-channel state: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING. Per channel, a register holds the current consumer index.
- A global `serving` bit per consumer marks consumers that are owned by a channel.
- IDLE: the channel scans consumers from 0 upward. The first consumer with (read_valid or write_valid) and !serving is claimed.
  - The claimed consumer's serving bit is set.
  - If read_valid is set, the channel latches the address, asserts mem_read_valid and goes to READ_WAITING.
  - Otherwise the channel latches address and data, asserts mem_write_valid and goes to WRITE_WAITING.
  - Read wins when both read_valid and write_valid are set for the same consumer. The write is served in a later grant.
- Same-cycle allocation is resolved in channel index order. Channel 0 picks first, and channel k skips any consumer claimed this cycle by channels 0..k-1. No consumer is ever owned by two channels.
- READ_WAITING: mem_read_valid and the address are held stable. On mem_read_ready:
  - mem_read_data is latched into consumer_read_data[owner].
  - consumer_read_ready[owner] is asserted.
  - mem_read_valid is deasserted and the state goes to READ_RELAYING.
- WRITE_WAITING: the same sequence using the mem_write_* signals. consumer_write_ready[owner] is asserted and the state goes to WRITE_RELAYING.
- READ_RELAYING: ready and data are held until consumer_read_valid[owner] == 0. Then ready is deasserted, serving[owner] is cleared and the state goes to IDLE. WRITE_RELAYING behaves the same with the write signals.
- Outputs for consumers not currently owned are 0. Memory outputs of IDLE channels are 0.

## Timing
- Reset (async) forces all channels to IDLE and clears serving. Every output goes to 0, including data and address buses. A reset mid-transaction abandons the transaction with no response.
- Grant: a request sampled at edge N produces mem_*_valid high after edge N, i.e. 1 cycle after the request.
- mem_*_ready sampled at edge M produces consumer_*_ready high after edge M. mem_*_valid is low in that same cycle.
- Minimum round trip with ready returned immediately: request to consumer ready is 2 cycles.
- Release: consumer valid low sampled at edge R drops ready after edge R, and the channel is IDLE in the cycle after R.
  - The freed consumer becomes eligible again at edge R+1.
  - The freed channel can grant at edge R+1.
- mem_*_ready seen in any state other than *_WAITING is ignored.
- Consumer valid must stay high until ready. Dropping it early is illegal; behaviour in that case is undefined and is not checked.

## Test plan
- Reset: hold reset 2 cycles with all inputs active, then assert reset mid-READ_WAITING. Required: every output is 0 immediately (async), and all channels are IDLE after release.
- Single read: consumer 0 reads 0xFF; memory returns 0xAB two cycles after mem_read_valid.
  - mem_read_address[0] = 0xFF one cycle after the request.
  - consumer_read_data[0] = 0xAB and consumer_read_ready[0] = 1 the cycle after mem_read_ready.
  - Ready clears one cycle after valid drops.
- Single write: consumer 1 writes 0xF0 to 0xF0. Required: mem_write_address = mem_write_data = 0xF0 on channel 0, and consumer_write_ready[1] follows mem_write_ready.
- Contention with NUM_CHANNELS = 2: consumers 0..3 all read at once.
  - Channels 0 and 1 grant consumers 0 and 1.
  - Consumers 2 and 3 are granted only after those consumers release.
  - No consumer is ever granted twice.
- Read+write on the same consumer: consumer 2 requests both. Required: the read completes first and the write is granted after the read release.
- Back-to-back: consumer 0 re-asserts read one cycle after its release. Required: it is granted with no lost cycles beyond the spec'd release-to-IDLE cycle.

Source files
------------

// File: rtl/dcache_mem_arbiter.sv
// Routes dcache per-consumer read/write requests onto NUM_CHANNELS memory channels.
// Each channel runs its own request/response FSM and claims the lowest free pending consumer.
module dcache_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_WAITING,
    S_WRITE_WAITING,
    S_READ_RELAYING,
    S_WRITE_RELAYING
  } state_t;

  state_t                 r_state [NUM_CHANNELS];
  state_t                 w_state_nxt [NUM_CHANNELS];
  logic [IDX_W-1:0]       r_owner [NUM_CHANNELS];
  logic [IDX_W-1:0]       w_owner_nxt [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]   r_addr [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]   w_addr_nxt [NUM_CHANNELS];
  // Holds write data while WRITE_WAITING and returned read data while READ_RELAYING.
  logic [DATA_BITS-1:0]   r_data [NUM_CHANNELS];
  logic [DATA_BITS-1:0]   w_data_nxt [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] r_serving, w_serving_nxt, w_claimed;
  logic                   w_found;
  logic [IDX_W-1:0]       w_pick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_serving <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_state[c] <= S_IDLE;
        r_owner[c] <= '0;
        r_addr[c]  <= '0;
        r_data[c]  <= '0;
      end
    end else begin
      r_serving <= w_serving_nxt;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_state[c] <= w_state_nxt[c];
        r_owner[c] <= w_owner_nxt[c];
        r_addr[c]  <= w_addr_nxt[c];
        r_data[c]  <= w_data_nxt[c];
      end
    end
  end

  // Channels allocate in index order; w_claimed carries this cycle's grants down the chain.
  always_comb begin
    w_serving_nxt = r_serving;
    w_claimed     = r_serving;
    w_found       = 1'b0;
    w_pick        = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_state_nxt[c] = r_state[c];
      w_owner_nxt[c] = r_owner[c];
      w_addr_nxt[c]  = r_addr[c];
      w_data_nxt[c]  = r_data[c];
      case (r_state[c])
        S_IDLE: begin
          w_found = 1'b0;
          w_pick  = '0;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (!w_found && (consumer_read_valid[i] || consumer_write_valid[i]) && !w_claimed[i]) begin
              w_found = 1'b1;
              w_pick  = IDX_W'(i);
            end
          end
          if (w_found) begin
            w_claimed[w_pick]     = 1'b1;
            w_serving_nxt[w_pick] = 1'b1;
            w_owner_nxt[c]        = w_pick;
            if (consumer_read_valid[w_pick]) begin
              w_state_nxt[c] = S_READ_WAITING;
              w_addr_nxt[c]  = consumer_read_address[w_pick];
            end else begin
              w_state_nxt[c] = S_WRITE_WAITING;
              w_addr_nxt[c]  = consumer_write_address[w_pick];
              w_data_nxt[c]  = consumer_write_data[w_pick];
            end
          end
        end
        S_READ_WAITING: begin
          if (mem_read_ready[c]) begin
            w_data_nxt[c]  = mem_read_data[c];
            w_state_nxt[c] = S_READ_RELAYING;
          end
        end
        S_WRITE_WAITING: begin
          if (mem_write_ready[c]) w_state_nxt[c] = S_WRITE_RELAYING;
        end
        S_READ_RELAYING: begin
          if (!consumer_read_valid[r_owner[c]]) begin
            w_serving_nxt[r_owner[c]] = 1'b0;
            w_state_nxt[c]            = S_IDLE;
          end
        end
        S_WRITE_RELAYING: begin
          if (!consumer_write_valid[r_owner[c]]) begin
            w_serving_nxt[r_owner[c]] = 1'b0;
            w_state_nxt[c]            = S_IDLE;
          end
        end
        default: w_state_nxt[c] = S_IDLE;
      endcase
    end
  end

  // All outputs decode from registered state only, so reset zeroes them immediately.
  always_comb begin
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    mem_read_valid       = '0;
    mem_read_address     = '0;
    mem_write_valid      = '0;
    mem_write_address    = '0;
    mem_write_data       = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (r_state[c])
        S_READ_WAITING: begin
          mem_read_valid[c]   = 1'b1;
          mem_read_address[c] = r_addr[c];
        end
        S_WRITE_WAITING: begin
          mem_write_valid[c]   = 1'b1;
          mem_write_address[c] = r_addr[c];
          mem_write_data[c]    = r_data[c];
        end
        S_READ_RELAYING: begin
          consumer_read_ready[r_owner[c]] = 1'b1;
          consumer_read_data[r_owner[c]]  = r_data[c];
        end
        S_WRITE_RELAYING: consumer_write_ready[r_owner[c]] = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Directed bench for dcache_mem_arbiter with 8 consumers sharing 2 memory channels.
module tb_dcache_mem_arbiter;
  localparam int AB = 8, DB = 8, NCO = 8, NCH = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [NCO-1:0]         rv, wv, rrdy, wrdy;
  logic [NCO-1:0][AB-1:0] ra, wa;
  logic [NCO-1:0][DB-1:0] wd, rd;
  logic [NCH-1:0]         mrv, mrr, mwv, mwr;
  logic [NCH-1:0][AB-1:0] mra, mwa;
  logic [NCH-1:0][DB-1:0] mrd, mwd;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  dcache_mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NCO), .NUM_CHANNELS(NCH)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(rrdy), .consumer_read_data(rd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(wrdy),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rrdy"}, 64'(rrdy), 64'h0);
    chk({tag, ".rd"},   64'(rd),   64'h0);
    chk({tag, ".wrdy"}, 64'(wrdy), 64'h0);
    chk({tag, ".mem"},  64'({mrv, mwv, mra, mwa, mwd}), 64'h0);
  endtask

  initial begin
    rv = '1; wv = '1; mrr = '1; mwr = '1;
    for (int i = 0; i < NCO; i++) begin
      ra[i] = AB'(8'h30 + i); wa[i] = AB'(8'h40 + i); wd[i] = DB'(8'h50 + i);
    end
    mrd = {8'hEE, 8'hDD};
    step(); step();
    chk_all_zero("reset_hold");

    rv = '0; wv = '0; mrr = '0; mwr = '0; ra = '0; wa = '0; wd = '0; mrd = '0;
    reset = 1'b0;
    step();
    chk_all_zero("post_reset_idle");

    // Reset while channel 0 is in READ_WAITING
    rv[0] = 1'b1; ra[0] = 8'h11;
    step();
    chk("midrst.mrv_before", 64'(mrv), 64'h1);
    chk("midrst.mra_before", 64'(mra[0]), 64'h11);
    #2 reset = 1'b1;
    #1 chk_all_zero("midrst_async");
    rv = '0; ra = '0;
    #1 reset = 1'b0;
    step();
    chk_all_zero("midrst_release");

    // Single read: consumer 0 @0xFF, memory answers 0xAB two cycles later
    rv[0] = 1'b1; ra[0] = 8'hFF;
    step();
    chk("rd.mrv", 64'(mrv), 64'h1);
    chk("rd.mra0", 64'(mra[0]), 64'hFF);
    chk("rd.rrdy_early", 64'(rrdy), 64'h0);
    step();
    chk("rd.mrv_hold", 64'(mrv), 64'h1);
    mrr[0] = 1'b1; mrd[0] = 8'hAB;
    step();
    mrr = '0; mrd = '0;
    chk("rd.rrdy", 64'(rrdy), 64'h1);
    chk("rd.rd0", 64'(rd[0]), 64'hAB);
    chk("rd.mrv_low", 64'(mrv), 64'h0);
    step();
    chk("rd.rrdy_hold", 64'(rrdy), 64'h1);
    chk("rd.rd0_hold", 64'(rd[0]), 64'hAB);
    rv[0] = 1'b0;
    step();
    chk("rd.rrdy_clr", 64'(rrdy), 64'h0);
    chk("rd.rd_clr", 64'(rd), 64'h0);
    chk("rd.idle", 64'(mrv), 64'h0);

    // Single write: consumer 1 writes 0xF0 to 0xF0
    wv[1] = 1'b1; wa[1] = 8'hF0; wd[1] = 8'hF0;
    step();
    chk("wr.mwv", 64'(mwv), 64'h1);
    chk("wr.mwa0", 64'(mwa[0]), 64'hF0);
    chk("wr.mwd0", 64'(mwd[0]), 64'hF0);
    chk("wr.wrdy_early", 64'(wrdy), 64'h0);
    mwr[0] = 1'b1;
    step();
    mwr = '0;
    chk("wr.wrdy", 64'(wrdy), 64'h2);
    chk("wr.mwv_low", 64'(mwv), 64'h0);
    wv[1] = 1'b0;
    step();
    chk("wr.wrdy_clr", 64'(wrdy), 64'h0);

    // Contention: consumers 0..3 read together on two channels
    rv[3:0] = 4'hF;
    for (int i = 0; i < 4; i++) ra[i] = AB'(8'h10 + i);
    step();
    chk("ct.mrv1", 64'(mrv), 64'h3);
    chk("ct.mra1", 64'(mra), 64'h1110);
    mrr = 2'b11; mrd = {8'hA1, 8'hA0};
    step();
    mrr = '0; mrd = '0;
    chk("ct.rrdy1", 64'(rrdy), 64'h3);
    chk("ct.rd1", 64'(rd), 64'hA1A0);
    chk("ct.mrv_low", 64'(mrv), 64'h0);
    step();
    chk("ct.no_regrant", 64'({rrdy, mrv}), 64'h0C);
    rv[1:0] = 2'b00;
    step();
    chk("ct.release", 64'({rrdy, mrv}), 64'h0);
    step();
    chk("ct.mrv2", 64'(mrv), 64'h3);
    chk("ct.mra2", 64'(mra), 64'h1312);
    mrr = 2'b11; mrd = {8'hB3, 8'hB2};
    step();
    mrr = '0; mrd = '0;
    chk("ct.rrdy2", 64'(rrdy), 64'hC);
    chk("ct.rd2", 64'(rd), 64'hB3B2_0000);
    rv[3:2] = 2'b00;
    step();
    chk("ct.done", 64'({rrdy, mrv}), 64'h0);
    ra = '0;

    // Read and write pending on consumer 2: read first, write after release
    rv[2] = 1'b1; ra[2] = 8'h22; wv[2] = 1'b1; wa[2] = 8'h33; wd[2] = 8'h44;
    step();
    chk("rw.mrv", 64'(mrv), 64'h1);
    chk("rw.mra0", 64'(mra[0]), 64'h22);
    chk("rw.mwv_none", 64'(mwv), 64'h0);
    mrr[0] = 1'b1; mrd[0] = 8'h5A;
    step();
    mrr = '0; mrd = '0;
    chk("rw.rrdy", 64'(rrdy), 64'h4);
    chk("rw.rd2", 64'(rd[2]), 64'h5A);
    chk("rw.wrdy_none", 64'(wrdy), 64'h0);
    rv[2] = 1'b0;
    step();
    chk("rw.release", 64'({rrdy, mwv}), 64'h0);
    step();
    chk("rw.mwv", 64'(mwv), 64'h1);
    chk("rw.mw0", 64'({mwa[0], mwd[0]}), 64'h3344);
    mwr[0] = 1'b1;
    step();
    mwr = '0;
    chk("rw.wrdy", 64'(wrdy), 64'h4);
    wv[2] = 1'b0;
    step();
    chk("rw.wrdy_clr", 64'(wrdy), 64'h0);
    ra = '0; wa = '0; wd = '0;

    // Back-to-back: consumer 0 re-requests right after its release edge
    rv[0] = 1'b1; ra[0] = 8'h77;
    step();
    chk("b2b.mrv1", 64'(mrv), 64'h1);
    mrr[0] = 1'b1; mrd[0] = 8'h99;
    step();
    mrr = '0; mrd = '0;
    chk("b2b.rrdy", 64'(rrdy), 64'h1);
    chk("b2b.rd0", 64'(rd[0]), 64'h99);
    rv[0] = 1'b0;
    step();
    chk("b2b.release", 64'(rrdy), 64'h0);
    rv[0] = 1'b1; ra[0] = 8'h78;
    step();
    chk("b2b.mrv2", 64'(mrv), 64'h1);
    chk("b2b.mra2", 64'(mra[0]), 64'h78);
    // Memory ready while not waiting must be ignored
    mwr = 2'b11;
    step();
    mwr = '0;
    chk("ign.wrdy", 64'({wrdy, mwv}), 64'h0);
    chk("ign.mrv_hold", 64'(mrv), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
